ps2_scancode_decoder: RTL and testbench

Converts the raw byte stream from the PS/2 receive path into key events. Input is the receiver's `word_ready` single-cycle pulse and 8-bit word. The decoder strips E0/F0/E1 prefixes and tracks the Shift/Ctrl/Alt modifier state. Non-key device responses go to a side channel so the host command logic can see them. Output is a 10-bit event `{ext, brk, code}` buffered in a small FIFO with a valid/ready handshake toward the consumer (keymap / UART / display logic).

---
 rtl/ps2_pkg.sv | 44 ++++
 rtl/ps2_event_fifo.sv | 58 +++++
 rtl/ps2_scancode_decoder.sv | 195 +++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and event layout for the PS/2 scan-code decoder.
package ps2_pkg;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_E1 = 8'hE1;

    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
    localparam logic [7:0] RSP_ECHO    = 8'hEE;
    localparam logic [7:0] RSP_RESEND  = 8'hFE;
    localparam logic [7:0] RSP_BAT_ERR = 8'hFC;
    localparam logic [7:0] RSP_ERR_LO  = 8'h00;
    localparam logic [7:0] RSP_ERR_HI  = 8'hFF;

    localparam logic [7:0] MOD_LSHIFT = 8'h12;
    localparam logic [7:0] MOD_RSHIFT = 8'h59;
    localparam logic [7:0] MOD_CTRL   = 8'h14;
    localparam logic [7:0] MOD_ALT    = 8'h11;

    localparam int         EV_W     = 10;
    localparam logic [2:0] SKIP_LEN = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXT    = 3'd1,
        ST_BRK    = 3'd2,
        ST_EXTBRK = 3'd3,
        ST_SKIP   = 3'd4
    } state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ev_t;

    function automatic logic is_response(input logic [7:0] b);
        return (b == RSP_ACK) || (b == RSP_BAT_OK) || (b == RSP_ECHO) ||
               (b == RSP_RESEND) || (b == RSP_BAT_ERR) ||
               (b == RSP_ERR_LO) || (b == RSP_ERR_HI);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small register-based event FIFO; pointers carry an extra wrap bit for full/empty.
module ps2_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             ck,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en, rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge ck or posedge reset) begin
            if (reset)
                mem_q[gi] <= '0;
            else if (wr_en && (wr_ptr_q[AW-1:0] == AW'(gi)))
                mem_q[gi] <= din;
        end
    end

    assign dout = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 byte stream to key events: prefix stripping, modifier tracking,
// device-response side channel and a buffered event output.
module ps2_scancode_decoder #(
    parameter int BIT_REVERSE = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT     = 2_000_000
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_brk,
    output logic       ev_ext,
    output logic       shift_st,
    output logic       ctrl_st,
    output logic       alt_st,
    output logic       sys_pulse,
    output logic [7:0] sys_byte,
    output logic       overflow,
    input  logic       clr_overflow,
    output logic [2:0] state
);
    import ps2_pkg::*;

    localparam logic [20:0] TMO_LIM = 21'(TIMEOUT);

    localparam int M_LSH = 0;
    localparam int M_RSH = 1;
    localparam int M_LCT = 2;
    localparam int M_RCT = 3;
    localparam int M_LAL = 4;
    localparam int M_RAL = 5;

    logic [7:0]  b_rev, b;
    state_e      state_q, state_d;
    logic [2:0]  skip_q, skip_d;
    logic [20:0] tmo_q, tmo_d;
    logic [5:0]  mod_q, mod_d;
    logic        sys_pulse_q, sys_pulse_d;
    logic [7:0]  sys_byte_q, sys_byte_d;
    logic        ovf_q, ovf_d;
    logic        emit, emit_ext, emit_brk;
    logic        fifo_full, fifo_empty, pop;
    ev_t         push_ev, head_ev;

    for (genvar gi = 0; gi < 8; gi++) begin : g_rev
        assign b_rev[gi] = byte_in[7-gi];
    end
    assign b = (BIT_REVERSE != 0) ? b_rev : byte_in;

    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        tmo_d       = tmo_q;
        sys_pulse_d = 1'b0;
        sys_byte_d  = sys_byte_q;
        emit        = 1'b0;
        emit_ext    = 1'b0;
        emit_brk    = 1'b0;
        if (byte_valid) begin
            tmo_d = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (b == SC_E0) begin
                        state_d = ST_EXT;
                    end else if (b == SC_F0) begin
                        state_d = ST_BRK;
                    end else if (b == SC_E1) begin
                        state_d = ST_SKIP;
                        skip_d  = SKIP_LEN;
                    end else if (is_response(b)) begin
                        sys_pulse_d = 1'b1;
                        sys_byte_d  = b;
                    end else begin
                        emit = 1'b1;
                    end
                end
                ST_EXT: begin
                    state_d = ST_IDLE;
                    if (b == SC_F0) begin
                        state_d = ST_EXTBRK;
                    end else if (b != MOD_LSHIFT && b != MOD_RSHIFT) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                    end
                end
                ST_BRK: begin
                    state_d  = ST_IDLE;
                    emit     = 1'b1;
                    emit_brk = 1'b1;
                end
                ST_EXTBRK: begin
                    state_d = ST_IDLE;
                    if (b != MOD_LSHIFT && b != MOD_RSHIFT) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        emit_brk = 1'b1;
                    end
                end
                ST_SKIP: begin
                    skip_d = skip_q - 1'b1;
                    if (skip_q == 3'd1) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            // A stalled prefix sequence is abandoned silently.
            tmo_d = tmo_q + 1'b1;
            if (tmo_d == TMO_LIM) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
                skip_d  = '0;
            end
        end else begin
            tmo_d = '0;
        end
    end

    assign push_ev = '{ext: emit_ext, brk: emit_brk, code: b};

    // Modifiers follow every emitted event, including ones the FIFO drops.
    always_comb begin
        mod_d = mod_q;
        if (emit) begin
            if (!emit_ext && b == MOD_LSHIFT) mod_d[M_LSH] = !emit_brk;
            if (!emit_ext && b == MOD_RSHIFT) mod_d[M_RSH] = !emit_brk;
            if (b == MOD_CTRL) begin
                if (emit_ext) mod_d[M_RCT] = !emit_brk;
                else          mod_d[M_LCT] = !emit_brk;
            end
            if (b == MOD_ALT) begin
                if (emit_ext) mod_d[M_RAL] = !emit_brk;
                else          mod_d[M_LAL] = !emit_brk;
            end
        end
    end

    assign pop = ev_ready && !fifo_empty;

    always_comb begin
        ovf_d = ovf_q;
        if (emit && fifo_full && !pop) ovf_d = 1'b1;
        if (clr_overflow)              ovf_d = 1'b0;
    end

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            skip_q      <= '0;
            tmo_q       <= '0;
            mod_q       <= '0;
            sys_pulse_q <= 1'b0;
            sys_byte_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            tmo_q       <= tmo_d;
            mod_q       <= mod_d;
            sys_pulse_q <= sys_pulse_d;
            sys_byte_q  <= sys_byte_d;
            ovf_q       <= ovf_d;
        end
    end

    ps2_event_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(EV_W)
    ) u_fifo (
        .ck   (ck),
        .reset(reset),
        .push (emit),
        .pop  (ev_ready),
        .din  (push_ev),
        .dout (head_ev),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign ev_valid  = !fifo_empty;
    assign ev_code   = head_ev.code;
    assign ev_brk    = head_ev.brk;
    assign ev_ext    = head_ev.ext;
    assign shift_st  = mod_q[M_LSH] | mod_q[M_RSH];
    assign ctrl_st   = mod_q[M_LCT] | mod_q[M_RCT];
    assign alt_st    = mod_q[M_LAL] | mod_q[M_RAL];
    assign sys_pulse = sys_pulse_q;
    assign sys_byte  = sys_byte_q;
    assign overflow  = ovf_q;
    assign state     = state_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench: one DUT in natural bit order, one in receiver bit order.
module tb_ps2_scancode_decoder;

    localparam int TMO = 16;

    logic       ck = 1'b0;
    logic       reset = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       ev_ready = 1'b0;
    logic       clr_overflow = 1'b0;

    logic       ev_valid, ev_brk, ev_ext, shift_st, ctrl_st, alt_st, sys_pulse, overflow;
    logic [7:0] ev_code, sys_byte;
    logic [2:0] state;

    logic       r_ev_valid, r_ev_brk, r_ev_ext, r_shift_st, r_ctrl_st, r_alt_st, r_sys_pulse, r_overflow;
    logic [7:0] r_ev_code, r_sys_byte;
    logic [2:0] r_state;

    logic [9:0] head, r_head;
    assign head   = {ev_ext, ev_brk, ev_code};
    assign r_head = {r_ev_ext, r_ev_brk, r_ev_code};

    int n_cmp = 0;
    int n_bad = 0;

    always #5 ck = ~ck;

    ps2_scancode_decoder #(.BIT_REVERSE(0), .FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
        .ck(ck), .reset(reset), .byte_valid(byte_valid), .byte_in(byte_in),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_brk(ev_brk),
        .ev_ext(ev_ext), .shift_st(shift_st), .ctrl_st(ctrl_st), .alt_st(alt_st),
        .sys_pulse(sys_pulse), .sys_byte(sys_byte), .overflow(overflow),
        .clr_overflow(clr_overflow), .state(state)
    );

    ps2_scancode_decoder #(.BIT_REVERSE(1), .FIFO_DEPTH(4), .TIMEOUT(TMO)) dut_rev (
        .ck(ck), .reset(reset), .byte_valid(byte_valid), .byte_in(byte_in),
        .ev_valid(r_ev_valid), .ev_ready(ev_ready), .ev_code(r_ev_code), .ev_brk(r_ev_brk),
        .ev_ext(r_ev_ext), .shift_st(r_shift_st), .ctrl_st(r_ctrl_st), .alt_st(r_alt_st),
        .sys_pulse(r_sys_pulse), .sys_byte(r_sys_byte), .overflow(r_overflow),
        .clr_overflow(clr_overflow), .state(r_state)
    );

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        @(posedge ck); #1;
        byte_valid = 1'b0;
    endtask

    task automatic pop_one();
        ev_ready = 1'b1;
        @(posedge ck); #1;
        ev_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ck); #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge ck); #1;
        reset = 1'b0;
        @(posedge ck); #1;
    endtask

    task automatic test_reset();
        send_byte(8'hF0);
        reset = 1'b1;
        #2;
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", state); end
        n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL rst_ev_valid: got %b want 0", ev_valid); end
        n_cmp++; if (head !== 10'h000) begin n_bad++; $display("FAIL rst_head: got %h want 000", head); end
        n_cmp++; if ({shift_st, ctrl_st, alt_st} !== 3'b000) begin n_bad++; $display("FAIL rst_mods: got %b want 000", {shift_st, ctrl_st, alt_st}); end
        n_cmp++; if ({sys_pulse, sys_byte, overflow} !== 10'h000) begin n_bad++; $display("FAIL rst_sys_ovf: got %h want 000", {sys_pulse, sys_byte, overflow}); end
        @(posedge ck); #1;
        reset = 1'b0;
        @(posedge ck); #1;
        // The aborted F0 must not turn the next make into a break.
        send_byte(8'h1C);
        n_cmp++; if (head !== 10'h01C) begin n_bad++; $display("FAIL rst_abort: got %h want 01C", head); end
        pop_one();
        $display("test_reset done");
    endtask

    task automatic test_make_break();
        do_reset();
        byte_valid = 1'b1;
        byte_in    = 8'h1C;
        n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL mb_pre_valid: got %b want 0", ev_valid); end
        @(posedge ck); #1;
        byte_valid = 1'b0;
        n_cmp++; if (ev_valid !== 1'b1) begin n_bad++; $display("FAIL mb_valid_n1: got %b want 1", ev_valid); end
        send_byte(8'hF0);
        send_byte(8'h1C);
        n_cmp++; if (head !== 10'h01C) begin n_bad++; $display("FAIL mb_make: got %h want 01C", head); end
        pop_one();
        n_cmp++; if (head !== 10'h11C || ev_valid !== 1'b1) begin n_bad++; $display("FAIL mb_break: got %h v=%b want 11C v=1", head, ev_valid); end
        pop_one();
        n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL mb_empty: got %b want 0", ev_valid); end
        $display("test_make_break done");
    endtask

    task automatic test_bit_reverse();
        do_reset();
        send_byte(8'h38);
        n_cmp++; if (r_head !== 10'h01C || r_ev_valid !== 1'b1) begin n_bad++; $display("FAIL rev_code: got %h v=%b want 01C v=1", r_head, r_ev_valid); end
        n_cmp++; if (head !== 10'h038) begin n_bad++; $display("FAIL norev_code: got %h want 038", head); end
        pop_one();
        $display("test_bit_reverse done");
    endtask

    task automatic test_extended();
        do_reset();
        send_byte(8'hE0); send_byte(8'h14);
        n_cmp++; if (ctrl_st !== 1'b1 || head !== 10'h214) begin n_bad++; $display("FAIL ext_rctrl_make: got ctrl=%b head=%h want ctrl=1 head=214", ctrl_st, head); end
        pop_one();
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
        n_cmp++; if (ctrl_st !== 1'b0 || head !== 10'h314) begin n_bad++; $display("FAIL ext_rctrl_brk: got ctrl=%b head=%h want ctrl=0 head=314", ctrl_st, head); end
        pop_one();
        send_byte(8'h12);
        n_cmp++; if (shift_st !== 1'b1 || head !== 10'h012) begin n_bad++; $display("FAIL lshift_make: got sh=%b head=%h want sh=1 head=012", shift_st, head); end
        pop_one();
        send_byte(8'hE0); send_byte(8'h12);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h12);
        n_cmp++; if (ev_valid !== 1'b0 || shift_st !== 1'b1) begin n_bad++; $display("FAIL fake_shift: got v=%b sh=%b want v=0 sh=1", ev_valid, shift_st); end
        send_byte(8'hE0); send_byte(8'h11);
        n_cmp++; if (alt_st !== 1'b1 || head !== 10'h211) begin n_bad++; $display("FAIL ralt_make: got alt=%b head=%h want alt=1 head=211", alt_st, head); end
        pop_one();
        $display("test_extended done");
    endtask

    task automatic test_pause();
        logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        do_reset();
        for (int i = 0; i < 8; i++) send_byte(seq[i]);
        n_cmp++; if (ev_valid !== 1'b0 || state !== 3'd0 || ctrl_st !== 1'b0) begin n_bad++; $display("FAIL pause_quiet: got v=%b st=%0d ctrl=%b want 0 0 0", ev_valid, state, ctrl_st); end
        send_byte(8'h1C);
        n_cmp++; if (head !== 10'h01C) begin n_bad++; $display("FAIL pause_next: got %h want 01C", head); end
        pop_one();
        n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL pause_single: got %b want 0", ev_valid); end
        $display("test_pause done");
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(codes[i]);
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
        // A dropped event alongside a clear leaves the flag clear.
        clr_overflow = 1'b1;
        send_byte(8'h36);
        clr_overflow = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clr_prio: got %b want 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (head !== {2'b00, codes[i]} || ev_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_order%0d: got %h v=%b want %h", i, head, ev_valid, {2'b00, codes[i]}); end
            pop_one();
        end
        n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drained: got %b want 0", ev_valid); end
        for (int i = 0; i < 5; i++) send_byte(codes[i]);
        clr_overflow = 1'b1;
        @(posedge ck); #1;
        clr_overflow = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clr: got %b want 0", overflow); end
        $display("test_overflow done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24); send_byte(8'h2D);
        ev_ready = 1'b1;
        send_byte(8'h3D);
        ev_ready = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_no_ovf: got %b want 0", overflow); end
        n_cmp++; if (head !== 10'h01D) begin n_bad++; $display("FAIL b2b_head: got %h want 01D", head); end
        pop_one(); pop_one(); pop_one();
        n_cmp++; if (head !== 10'h03D || ev_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_last: got %h v=%b want 03D v=1", head, ev_valid); end
        pop_one();
        pop_one();
        n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty_pop: got %b want 0", ev_valid); end
        $display("test_back_to_back done");
    endtask

    task automatic test_timeout();
        do_reset();
        send_byte(8'hF0);
        idle(5);
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL tmo_hold: got %0d want 2", state); end
        send_byte(8'h1C);
        n_cmp++; if (head !== 10'h11C) begin n_bad++; $display("FAIL tmo_short_brk: got %h want 11C", head); end
        pop_one();
        send_byte(8'hF0);
        idle(TMO + 4);
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL tmo_abort: got %0d want 0", state); end
        send_byte(8'h1C);
        n_cmp++; if (head !== 10'h01C) begin n_bad++; $display("FAIL tmo_make: got %h want 01C", head); end
        pop_one();
        $display("test_timeout done");
    endtask

    task automatic test_sys();
        do_reset();
        send_byte(8'hFA);
        n_cmp++; if (sys_pulse !== 1'b1 || sys_byte !== 8'hFA) begin n_bad++; $display("FAIL sys_pulse: got p=%b b=%h want p=1 b=FA", sys_pulse, sys_byte); end
        n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL sys_no_event: got %b want 0", ev_valid); end
        @(posedge ck); #1;
        n_cmp++; if (sys_pulse !== 1'b0 || sys_byte !== 8'hFA) begin n_bad++; $display("FAIL sys_hold: got p=%b b=%h want p=0 b=FA", sys_pulse, sys_byte); end
        $display("test_sys done");
    endtask

    initial begin
        @(posedge ck); #1;
        test_reset();
        test_make_break();
        test_bit_reverse();
        test_extended();
        test_pause();
        test_overflow();
        test_back_to_back();
        test_timeout();
        test_sys();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
